// File: rtl/gpio_pkg.sv
// Shared definitions for the MCU GPIO input conditioning paths.
package gpio_pkg;

  // Debounce FSM encoding
  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_e;

  // 10 ms at 25 MHz
  localparam int unsigned DEBOUNCE_CYCLES_25MHZ_10MS = 250000;

  // Width of the wrapping press counter
  localparam int unsigned PRESS_CNT_W = 16;

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser for an asynchronous pad level, with a configurable reset value.
module gpio_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability chain: only the second stage is used downstream
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/gpio_in_debounce.sv
// Push-button input conditioner: synchronise, debounce, edge pulses, sticky press
// flag with acknowledge, overrun indication and a wrapping press counter.
module gpio_in_debounce
  import gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_25MHZ_10MS,
  parameter int unsigned CNT_W           = 18,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter logic        IDLE_LEVEL      = 1'b1
) (
  input  logic                   clk25,
  input  logic                   fpga_rst,
  input  logic                   pad_in,
  input  logic                   event_ack,
  output logic                   level_out,
  output logic                   rise_pulse,
  output logic                   fall_pulse,
  output logic                   event_flag,
  output logic                   overrun,
  output logic [PRESS_CNT_W-1:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                   pad_s2;
  deb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   flag_q, flag_d;
  logic                   ovr_q, ovr_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic                   differ_c;
  logic                   commit_c;
  logic                   press_c;

  gpio_sync2 #(
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk_i (clk25),
    .rst_i (fpga_rst),
    .d_i   (pad_in),
    .q_o   (pad_s2)
  );

  assign differ_c = (pad_s2 != level_q);

  // FSM state and stability counter register
  always_ff @(posedge clk25 or posedge fpga_rst) begin
    if (fpga_rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count consecutive cycles the synchronised pad disagrees with the output
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      STABLE: begin
        if (differ_c) begin
          state_d = CHANGING;
          cnt_d   = CNT_W'(1);
        end
      end
      CHANGING: begin
        if (!differ_c || (cnt_q == CNT_LAST)) begin
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Output decode: commit, edge pulses, press bookkeeping
  always_comb begin
    commit_c    = (state_q == CHANGING) && differ_c && (cnt_q == CNT_LAST);
    level_d     = commit_c ? pad_s2 : level_q;
    rise_d      = commit_c & pad_s2;
    fall_d      = commit_c & ~pad_s2;
    press_c     = ACTIVE_LOW ? fall_d : rise_d;
    press_cnt_d = press_c ? press_cnt_q + PRESS_CNT_W'(1) : press_cnt_q;
    // a press wins over ack for the flag; ack always drops overrun
    flag_d      = press_c | (flag_q & ~event_ack);
    ovr_d       = event_ack ? 1'b0 : (ovr_q | (press_c & flag_q));
  end

  // Registered outputs
  always_ff @(posedge clk25 or posedge fpga_rst) begin
    if (fpga_rst) begin
      level_q     <= IDLE_LEVEL;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      flag_q      <= 1'b0;
      ovr_q       <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      level_q     <= level_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      flag_q      <= flag_d;
      ovr_q       <= ovr_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign event_flag = flag_q;
  assign overrun    = ovr_q;
  assign press_cnt  = press_cnt_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce with DEBOUNCE_CYCLES = 8.
module tb_gpio_in_debounce;

  typedef struct packed {
    logic        rise;
    logic        fall;
    logic        level;
    logic        flag;
    logic        ovr;
    logic [15:0] cnt;
    logic [31:0] cyc;
  } exp_t;

  logic        clk25;
  logic        fpga_rst;
  logic        pad_in;
  logic        event_ack;
  logic        level_out;
  logic        rise_pulse;
  logic        fall_pulse;
  logic        event_flag;
  logic        overrun;
  logic [15:0] press_cnt;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 0;

  // reference model of the sticky state
  logic        m_flag = 1'b0;
  logic        m_ovr  = 1'b0;
  logic [15:0] m_cnt  = 16'h0000;

  gpio_in_debounce #(
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (18),
    .ACTIVE_LOW      (1'b1),
    .IDLE_LEVEL      (1'b1)
  ) dut (
    .clk25      (clk25),
    .fpga_rst   (fpga_rst),
    .pad_in     (pad_in),
    .event_ack  (event_ack),
    .level_out  (level_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .event_flag (event_flag),
    .overrun    (overrun),
    .press_cnt  (press_cnt)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  always @(posedge clk25) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every edge pulse must match the head of the scoreboard, at the predicted cycle
  always @(negedge clk25) begin
    exp_t a;
    exp_t e;
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse: no pulse seen, expected rise=%0b fall=%0b at cycle %0d", e.rise, e.fall, e.cyc);
    end
    if (rise_pulse || fall_pulse) begin
      a = '{rise: rise_pulse, fall: fall_pulse, level: level_out, flag: event_flag,
            ovr: overrun, cnt: press_cnt, cyc: cyc};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: rise=%0b fall=%0b at cycle %0d, none expected", rise_pulse, fall_pulse, cyc);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL pulse_event: got r%0b f%0b lvl%0b flg%0b ovr%0b cnt%0h cyc%0d expected r%0b f%0b lvl%0b flg%0b ovr%0b cnt%0h cyc%0d",
                   a.rise, a.fall, a.level, a.flag, a.ovr, a.cnt, a.cyc,
                   e.rise, e.fall, e.level, e.flag, e.ovr, e.cnt, e.cyc);
        end
      end
    end
  end

  // Drive a clean step and predict the committed edge 10 cycles later; optional ack at commit
  task automatic step(input logic lvl, input bit ack_at_commit);
    exp_t e;
    @(negedge clk25);
    pad_in = lvl;
    if (!lvl) begin
      m_cnt  = m_cnt + 16'd1;
      m_ovr  = ack_at_commit ? 1'b0 : (m_ovr | m_flag);
      m_flag = 1'b1;
    end
    e = '{rise: lvl, fall: ~lvl, level: lvl, flag: m_flag, ovr: m_ovr, cnt: m_cnt, cyc: cyc + 10};
    sb.push_back(e);
    if (ack_at_commit) begin
      repeat (9) @(negedge clk25);
      event_ack = 1'b1;
      @(negedge clk25);
      event_ack = 1'b0;
      repeat (10) @(negedge clk25);
    end else begin
      repeat (20) @(negedge clk25);
    end
  endtask

  task automatic ack_pulse();
    @(negedge clk25);
    event_ack = 1'b1;
    @(negedge clk25);
    event_ack = 1'b0;
    m_flag = 1'b0;
    m_ovr  = 1'b0;
    chk("ack_clears_flag", 32'(event_flag), 32'(m_flag));
    chk("ack_clears_ovr", 32'(overrun), 32'(m_ovr));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    fpga_rst  = 1'b1;
    pad_in    = 1'b1;
    event_ack = 1'b0;
    repeat (3) @(negedge clk25);
    chk("rst_level", 32'(level_out), 32'(1));
    chk("rst_pulses", 32'({rise_pulse, fall_pulse}), 32'(0));
    chk("rst_flag", 32'(event_flag), 32'(0));
    chk("rst_ovr", 32'(overrun), 32'(0));
    chk("rst_cnt", 32'(press_cnt), 32'(0));
    fpga_rst = 1'b0;

    // idle pad: nothing must happen
    repeat (50) @(negedge clk25);
    chk("idle_level", 32'(level_out), 32'(1));
    chk("idle_flag", 32'(event_flag), 32'(0));
    chk("idle_cnt", 32'(press_cnt), 32'(0));

    // clean press and release
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("after_release_cnt", 32'(press_cnt), 32'(1));
    chk("after_release_flag", 32'(event_flag), 32'(1));

    // bounce shorter than the window is rejected
    @(negedge clk25);
    pad_in = 1'b0;
    repeat (5) @(negedge clk25);
    pad_in = 1'b1;
    repeat (2) @(negedge clk25);
    pad_in = 1'b0;
    repeat (5) @(negedge clk25);
    pad_in = 1'b1;
    repeat (12) @(negedge clk25);
    chk("bounce_level", 32'(level_out), 32'(1));
    chk("bounce_cnt", 32'(press_cnt), 32'(1));

    // second press without ack -> overrun
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("overrun_set", 32'(overrun), 32'(1));
    chk("two_press_cnt", 32'(press_cnt), 32'(2));
    ack_pulse();

    // ack coincident with a press: flag stays, overrun cleared
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("ack_press_flag", 32'(event_flag), 32'(1));
    chk("ack_press_ovr", 32'(overrun), 32'(0));
    chk("ack_press_cnt", 32'(press_cnt), 32'(4));
    ack_pulse();

    // counter wrap from 0xFFFF
    @(negedge clk25);
    force dut.press_cnt_q = 16'hFFFF;
    @(negedge clk25);
    release dut.press_cnt_q;
    m_cnt = 16'hFFFF;
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("wrap_cnt", 32'(press_cnt), 32'(0));

    // reset mid-debounce with pad held low
    @(negedge clk25);
    pad_in = 1'b0;
    repeat (7) @(negedge clk25);
    fpga_rst = 1'b1;
    #1;
    chk("midrst_level", 32'(level_out), 32'(1));
    chk("midrst_flag", 32'(event_flag), 32'(0));
    chk("midrst_cnt", 32'(press_cnt), 32'(0));
    m_flag = 1'b0;
    m_ovr  = 1'b0;
    m_cnt  = 16'h0000;
    repeat (2) @(negedge clk25);
    fpga_rst = 1'b0;
    e = '{rise: 1'b0, fall: 1'b1, level: 1'b0, flag: 1'b1, ovr: 1'b0, cnt: 16'h0001, cyc: cyc + 10};
    sb.push_back(e);
    repeat (20) @(negedge clk25);
    chk("midrst_requalified_level", 32'(level_out), 32'(0));

    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Input-side conditioner for a push-button/GPIO pad. It is the receive path that feeds a clean level and event indications to the MCU GPIO input.
- Synchronises the raw pad, rejects bounce shorter than a programmable window, and emits one-cycle edge pulses.
- Keeps a sticky press flag with an MCU acknowledge handshake, an overrun indicator and a wrapping press counter.
- Sits between the pad (button2-class inout, input direction) and the AL_MCU gpio_hN_in port, in the clk25 domain.

Parameters:
- DEBOUNCE_CYCLES, 250000: stable cycles required to accept a level change (10 ms at 25 MHz). Legal range 2..2^CNT_W.
- CNT_W, 18: width of the debounce counter.
- ACTIVE_LOW, 1: 1 = pressed when pad is 0; selects which edge is a "press".
- IDLE_LEVEL, 1'b1: reset value of the synchroniser flops and the debounced level.

Ports:
- clk25  input  1  single block clock, 25 MHz system clock from sys_pll
- fpga_rst  input  1  asynchronous, active-high reset
- pad_in  input  1  raw asynchronous pad level
- event_ack  input  1  one-cycle MCU acknowledge; clears event_flag and overrun
- level_out  output  1  debounced level; drives the MCU gpio_hN_in
- rise_pulse  output  1  one-cycle pulse on an accepted 0->1 transition
- fall_pulse  output  1  one-cycle pulse on an accepted 1->0 transition
- event_flag  output  1  sticky; set on an accepted press
- overrun  output  1  sticky; set on a press while event_flag is already 1
- press_cnt  output  16  accepted presses, wraps modulo 2^16

Behaviour:
- Reset (async assert, release synchronous to clk25):
  - sync flops = IDLE_LEVEL; level_out = IDLE_LEVEL.
  - rise_pulse, fall_pulse, event_flag, overrun = 0; press_cnt = 0; counter = 0; state = STABLE.
- Synchroniser: two flops, pad_in -> s1 -> s2. Only s2 is used downstream.
- FSM states: STABLE, CHANGING.
  - STABLE: counter held at 0. If s2 != level_out, go to CHANGING with counter = 1.
  - CHANGING, s2 == level_out: bounce rejected. Go to STABLE, counter = 0, no output change.
  - CHANGING, s2 != level_out, counter < DEBOUNCE_CYCLES-1: counter + 1.
  - CHANGING, s2 != level_out, counter == DEBOUNCE_CYCLES-1: commit. level_out <= s2, go to STABLE, counter = 0.
- Latency: a clean step on pad_in changes level_out exactly 2 + DEBOUNCE_CYCLES clk25 cycles after the first sampling edge.
- Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no output activity.
- Edge pulses:
  - Asserted in the cycle level_out changes, one cycle wide. rise for 0->1, fall for 1->0.
  - Never both high. Never asserted for a rejected bounce.
- Press definition: fall_pulse when ACTIVE_LOW = 1, else rise_pulse.
- On press:
  - press_cnt + 1, wrapping 0xFFFF -> 0x0000.
  - event_flag <= 1.
  - If event_flag was already 1 and event_ack is low, overrun <= 1.
- event_ack:
  - Clears event_flag and overrun on the next edge.
  - If a press coincides with ack: event_flag stays 1 (set wins), overrun is cleared (the new event is the one pending).
- Reset mid-debounce: FSM is aborted and all state returns to reset values. A held pad level different from IDLE_LEVEL is re-qualified from scratch after release.
- Counter never exceeds DEBOUNCE_CYCLES-1. No arithmetic overflow path exists.

Decomposition:
- Shared package (gpio_pkg):
  - FSM state encoding (STABLE = 1'b0, CHANGING = 1'b1).
  - Default DEBOUNCE_CYCLES_25MHZ_10MS = 250000.
  - PRESS_CNT_W = 16.
- One natural sub-module: gpio_sync2, the two-flop synchroniser with reset value parameter. It is reusable for the other MCU GPIO input paths.
- Debounce FSM, edge logic and event/counter logic stay in gpio_in_debounce.

Test Plan (DEBOUNCE_CYCLES = 8, ACTIVE_LOW = 1, IDLE_LEVEL = 1):
- Reset then pad_in held at 1 for 50 cycles -> level_out = 1, no pulses, event_flag = 0, press_cnt = 0.
- Clean 1->0 step on pad_in -> fall_pulse high exactly 10 cycles later for 1 cycle, level_out = 0, event_flag = 1, press_cnt = 1. Then 0->1 step -> rise_pulse after 10 cycles, press_cnt stays 1.
- Bounce: pad_in low 5 cycles, high 2, low 5, high -> no pulses, level_out stays 1. Then low for 20 cycles -> single fall_pulse 10 cycles after the last low edge.
- Two presses without ack -> event_flag = 1, overrun = 1, press_cnt = 2. event_ack pulse -> both 0 on the next cycle.
- event_ack asserted in the same cycle as fall_pulse -> event_flag = 1, overrun = 0.
- Preload via 65536 presses (or force press_cnt = 0xFFFF) then one press -> press_cnt = 0x0000.
- fpga_rst asserted at counter = 5 with pad held low -> level_out = 1 immediately. After release, fall_pulse occurs 10 cycles later.
